// File: rtl/full_mat_pkg.sv
// Shared types and fixed-point helpers for the cumulative forward-kinematics chain.
package full_mat_pkg;
  localparam int FM_W    = 27;
  localparam int FM_FRAC = 16;

  typedef logic signed [FM_W-1:0] fixed_t;

  localparam fixed_t ONE = fixed_t'(1) <<< FM_FRAC;

  typedef enum logic [2:0] {IDLE, LOAD, ISSUE, DRAIN, DONE} state_t;

  // Floor-shift a dot-product sum back to fixed point and clamp to a w-bit signed range.
  function automatic logic signed [63:0] sat_shift(input logic signed [63:0] sum,
                                                   input int w, input int frac);
    logic signed [63:0] v, hi, lo;
    v  = sum >>> frac;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi)      return hi;
    else if (v < lo) return lo;
    else             return v;
  endfunction
endpackage

// File: rtl/full_mat_dot4.sv
// Write-back path: tags ride alongside the external multiplier, lane products are summed,
// shifted and saturated when the matching result returns.
module full_mat_dot4
  import full_mat_pkg::*;
#(
  parameter int W        = FM_W,
  parameter int FRAC     = FM_FRAC,
  parameter int MULT_LAT = 5,
  parameter int TW       = 7
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_en,
  input  logic                  i_vld,
  input  logic [TW-1:0]         i_tag,
  input  logic [3:0][2*W-1:0]   i_result,
  output logic                  o_wr_en,
  output logic [TW-1:0]         o_wr_tag,
  output logic [W-1:0]          o_wr_data
);
  logic [MULT_LAT:1]          r_vld_pipe;
  logic [MULT_LAT:1][TW-1:0]  r_tag_pipe;
  logic signed [2*W+1:0]      w_sum;

  // Advances only with the multiplier clock enable so tags stay aligned with products.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_vld_pipe <= '0;
      r_tag_pipe <= '0;
    end else if (i_en) begin
      for (int i = MULT_LAT; i > 1; i--) begin
        r_vld_pipe[i] <= r_vld_pipe[i-1];
        r_tag_pipe[i] <= r_tag_pipe[i-1];
      end
      r_vld_pipe[1] <= i_vld;
      r_tag_pipe[1] <= i_tag;
    end
  end

  always_comb begin
    w_sum = '0;
    for (int j = 0; j < 4; j++)
      w_sum = w_sum + (2*W+2)'($signed(i_result[j]));
  end

  assign o_wr_en   = r_vld_pipe[MULT_LAT];
  assign o_wr_tag  = r_tag_pipe[MULT_LAT];
  assign o_wr_data = W'(sat_shift(64'(w_sum), W, FRAC));
endmodule

// File: rtl/full_mat_chain.sv
// Cumulative product chain T0*T1*...*Tk over a shared 4-lane multiplier, one output
// element per issue cycle, with a drain gap between stages to avoid read-after-write.
module full_mat_chain
  import full_mat_pkg::*;
#(
  parameter int N_JOINTS = 6,
  parameter int W        = FM_W,
  parameter int FRAC     = FM_FRAC,
  parameter int MULT_LAT = 5
) (
  input  logic                                 i_clk,
  input  logic                                 i_rst,
  input  logic                                 i_en,
  input  logic                                 i_start,
  input  logic [N_JOINTS-1:0][2:0][3:0][W-1:0] i_mat_in,
  input  logic [3:0][2*W-1:0]                  i_mult_result,
  output logic [3:0][W-1:0]                    o_mult_dataa,
  output logic [3:0][W-1:0]                    o_mult_datab,
  output logic                                 o_mult_en,
  output logic                                 o_busy,
  output logic                                 o_done,
  output logic [N_JOINTS-1:0][3:0][3:0][W-1:0] o_full_matrix
);
  localparam int SW = (N_JOINTS > 1) ? $clog2(N_JOINTS) : 1;
  localparam int CW = $clog2(((MULT_LAT > 12) ? MULT_LAT : 12) + 1);
  localparam int TW = SW + 4;
  localparam logic [W-1:0]  L_ONE      = W'(1) << FRAC;
  localparam logic [SW-1:0] LAST_STAGE = SW'(N_JOINTS - 1);
  localparam logic [CW-1:0] ISSUE_LAST = CW'(11);
  localparam logic [CW-1:0] DRAIN_LAST = CW'(MULT_LAT - 1);

  state_t                               r_state;
  logic [CW-1:0]                        r_cnt;
  logic [SW-1:0]                        r_stage;
  logic                                 r_busy, r_done;
  logic [3:0][W-1:0]                    r_dataa, r_datab;
  logic [N_JOINTS-1:0][2:0][3:0][W-1:0] r_t;
  logic [N_JOINTS-1:0][3:0][3:0][W-1:0] r_full;

  logic                                 w_op_vld, w_op_load;
  logic [SW-1:0]                        w_op_stage, w_prev_stage;
  logic [3:0]                           w_op_elem;
  logic [1:0]                           w_op_r, w_op_c;
  logic [3:0][W-1:0]                    w_dataa, w_datab;
  logic                                 w_wr_en;
  logic [TW-1:0]                        w_wr_tag;
  logic [W-1:0]                         w_wr_data;

  // Look ahead one cycle: operands are registered so they sit on the bus during ISSUE.
  always_comb begin
    w_op_vld   = 1'b0;
    w_op_load  = 1'b0;
    w_op_stage = r_stage;
    w_op_elem  = '0;
    unique case (r_state)
      LOAD: if (N_JOINTS > 1) begin
        w_op_vld   = 1'b1;
        w_op_load  = 1'b1;
        w_op_stage = SW'(1);
      end
      ISSUE: if (r_cnt != ISSUE_LAST) begin
        w_op_vld  = 1'b1;
        w_op_elem = r_cnt[3:0] + 4'd1;
      end
      DRAIN: if (r_cnt == DRAIN_LAST && r_stage != LAST_STAGE) begin
        w_op_vld   = 1'b1;
        w_op_stage = r_stage + 1'b1;
      end
      default: ;
    endcase
  end

  assign w_op_r       = w_op_elem[3:2];
  assign w_op_c       = w_op_elem[1:0];
  assign w_prev_stage = w_op_stage - 1'b1;

  // While leaving LOAD the registers are still being filled, so read straight from the input.
  always_comb begin
    w_dataa = '0;
    w_datab = '0;
    if (w_op_vld) begin
      for (int j = 0; j < 4; j++)
        w_dataa[j] = w_op_load ? i_mat_in[0][w_op_r][j] : r_full[w_prev_stage][w_op_r][j];
      for (int j = 0; j < 3; j++)
        w_datab[j] = w_op_load ? i_mat_in[w_op_stage][j][w_op_c] : r_t[w_op_stage][j][w_op_c];
      w_datab[3] = (w_op_c == 2'd3) ? L_ONE : '0;
    end
  end

  full_mat_dot4 #(.W(W), .FRAC(FRAC), .MULT_LAT(MULT_LAT), .TW(TW)) u_dot4 (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_en      (i_en),
    .i_vld     (r_state == ISSUE),
    .i_tag     ({r_stage, r_cnt[3:0]}),
    .i_result  (i_mult_result),
    .o_wr_en   (w_wr_en),
    .o_wr_tag  (w_wr_tag),
    .o_wr_data (w_wr_data)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_stage <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_dataa <= '0;
      r_datab <= '0;
      r_t     <= '0;
      r_full  <= '0;
    end else if (i_en) begin
      r_done  <= 1'b0;
      r_dataa <= w_dataa;
      r_datab <= w_datab;
      unique case (r_state)
        IDLE: if (i_start) begin
          r_state <= LOAD;
          r_busy  <= 1'b1;
        end
        LOAD: begin
          r_t            <= i_mat_in;
          r_full[0][2:0] <= i_mat_in[0];
          for (int k = 0; k < N_JOINTS; k++)
            r_full[k][3] <= {L_ONE, {(3*W){1'b0}}};
          r_cnt <= '0;
          if (N_JOINTS == 1) begin
            r_state <= DONE;
            r_done  <= 1'b1;
          end else begin
            r_state <= ISSUE;
            r_stage <= SW'(1);
          end
        end
        ISSUE: if (r_cnt == ISSUE_LAST) begin
          r_state <= DRAIN;
          r_cnt   <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
        DRAIN: if (r_cnt == DRAIN_LAST) begin
          r_cnt <= '0;
          if (r_stage == LAST_STAGE) begin
            r_state <= DONE;
            r_done  <= 1'b1;
          end else begin
            r_state <= ISSUE;
            r_stage <= r_stage + 1'b1;
          end
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
        DONE: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
      if (w_wr_en)
        r_full[w_wr_tag[TW-1:4]][w_wr_tag[3:2]][w_wr_tag[1:0]] <= w_wr_data;
    end
  end

  assign o_mult_dataa  = r_dataa;
  assign o_mult_datab  = r_datab;
  assign o_mult_en     = i_en;
  assign o_busy        = r_busy;
  assign o_done        = r_done;
  assign o_full_matrix = r_full;
endmodule

// File: tb/tb_full_mat_chain.sv
// Randomized bench for full_mat_chain: ideal pipelined multiplier plus a matrix-product reference.
module tb_full_mat_chain;
  import full_mat_pkg::*;

  localparam int N    = 6;
  localparam int W    = 27;
  localparam int FRAC = 16;
  localparam int LAT  = 5;
  localparam longint ONE_L = 64'sd1 <<< FRAC;
  localparam longint HI    = (64'sd1 <<< (W - 1)) - 64'sd1;
  localparam longint LO    = -HI - 64'sd1;

  logic clk = 1'b0;
  logic rst, en, start;
  logic [N-1:0][2:0][3:0][W-1:0] mat_in;
  logic [3:0][2*W-1:0]           mult_result;
  logic [3:0][W-1:0]             dataa, datab;
  logic                          mult_en, busy, done;
  logic [N-1:0][3:0][3:0][W-1:0] fm;

  int n_cmp = 0;
  int n_err = 0;

  longint T [N][3][4];
  longint E [N][4][4];

  logic [3:0][2*W-1:0] mprod;
  logic [3:0][2*W-1:0] mpipe [LAT];

  always #5 clk = ~clk;

  full_mat_chain #(.N_JOINTS(N), .W(W), .FRAC(FRAC), .MULT_LAT(LAT)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_en          (en),
    .i_start       (start),
    .i_mat_in      (mat_in),
    .i_mult_result (mult_result),
    .o_mult_dataa  (dataa),
    .o_mult_datab  (datab),
    .o_mult_en     (mult_en),
    .o_busy        (busy),
    .o_done        (done),
    .o_full_matrix (fm)
  );

  // Ideal external multiplier: LAT-deep, stalls with mult_en.
  always_comb begin
    for (int j = 0; j < 4; j++)
      mprod[j] = (2*W)'($signed(dataa[j])) * (2*W)'($signed(datab[j]));
  end

  always @(posedge clk) begin
    if (mult_en) begin
      mpipe[0] <= mprod;
      for (int i = 1; i < LAT; i++) mpipe[i] <= mpipe[i-1];
    end
  end

  assign mult_result = mpipe[LAT-1];

  task automatic check(input string tag, input longint got, input longint exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint fmv(input int k, input int r, input int c);
    fixed_t v;
    v = fm[k][r][c];
    return longint'(v);
  endfunction

  function automatic longint satf(input longint s);
    longint v;
    v = s >>> FRAC;
    if (v > HI) return HI;
    if (v < LO) return LO;
    return v;
  endfunction

  // 0 identity, 1 x-translation, 2 z-rotation 90deg, 3 diag 16.0, 4 small random, 5 full-range random
  task automatic set_mats(input int mode);
    longint v;
    fixed_t rv;
    for (int k = 0; k < N; k++)
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 4; c++) begin
          case (mode)
            0: v = (r == c) ? ONE_L : 0;
            1: v = (r == c || (r == 0 && c == 3)) ? ONE_L : 0;
            2: v = (r == 0 && c == 1) ? -ONE_L : ((r == 1 && c == 0) || (r == 2 && c == 2)) ? ONE_L : 0;
            3: v = (r == c) ? 16 * ONE_L : 0;
            4: v = longint'($urandom_range(262144)) - 131072;
            default: begin
              rv = fixed_t'($urandom);
              v  = longint'(rv);
            end
          endcase
          T[k][r][c]      = v;
          mat_in[k][r][c] = W'(v);
        end
  endtask

  // Chained product of 4x4 homogeneous matrices, each step floored and clamped.
  task automatic model();
    longint s, tj;
    for (int k = 0; k < N; k++)
      for (int c = 0; c < 4; c++) E[k][3][c] = (c == 3) ? ONE_L : 0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 4; c++) E[0][r][c] = T[0][r][c];
    for (int k = 1; k < N; k++)
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 4; c++) begin
          s = 0;
          for (int j = 0; j < 4; j++) begin
            tj = (j < 3) ? T[k][j][c] : ((c == 3) ? ONE_L : 0);
            s  = s + E[k-1][r][j] * tj;
          end
          E[k][r][c] = satf(s);
        end
  endtask

  task automatic check_fm(input string tag);
    for (int k = 0; k < N; k++)
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          check($sformatf("%s fm[%0d][%0d][%0d]", tag, k, r, c), fmv(k, r, c), E[k][r][c]);
  endtask

  task automatic run_op(input string tag, input int n_low, input bit poke);
    bit low_at [100];
    int cyc, done_cyc, poke_cyc, c;
    for (int i = 0; i < 100; i++) low_at[i] = 1'b0;
    for (int i = 0; i < n_low; ) begin
      c = $urandom_range(70, 3);
      if (!low_at[c]) begin
        low_at[c] = 1'b1;
        i++;
      end
    end
    poke_cyc = poke ? $urandom_range(60, 5) : -1;
    model();
    en = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; cyc = 1; done_cyc = -1;
    check({tag, " busy_in_load"}, longint'(busy), 1);
    while (done_cyc < 0 && cyc < 300) begin
      if (done) done_cyc = cyc;
      else begin
        en    = (cyc < 100) ? !low_at[cyc] : 1'b1;
        start = (cyc == poke_cyc);
        @(posedge clk); #1;
        cyc++;
      end
    end
    check({tag, " done_cycle"}, longint'(done_cyc), 87 + n_low);
    // A start in the DONE cycle must not launch a new operation.
    en = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, " done_pulse_width"}, longint'(done), 0);
    check({tag, " busy_after_done"}, longint'(busy), 0);
    check({tag, " dataa_idle_zero"}, longint'(dataa != '0), 0);
    check_fm(tag);
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; start = 1'b0; mat_in = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset busy", longint'(busy), 0);
    check("reset done", longint'(done), 0);
    check("reset dataa", longint'(dataa != '0), 0);
    check("reset datab", longint'(datab != '0), 0);
    check("reset fm", longint'(fm != '0), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    en = 1'b0; #1;
    check("mult_en follows en", longint'(mult_en), 0);
    en = 1'b1; #1;
    check("mult_en follows en hi", longint'(mult_en), 1);

    set_mats(0); run_op("ident", 0, 1'b0);
    check("ident [5][1][1]", fmv(5, 1, 1), 65536);
    check("ident [5][0][1]", fmv(5, 0, 1), 0);

    set_mats(1); run_op("trans", 0, 1'b0);
    check("trans [5][0][3]", fmv(5, 0, 3), 393216);
    check("trans [2][0][3]", fmv(2, 0, 3), 196608);

    set_mats(2); run_op("rotz", 0, 1'b0);
    check("rotz [1][0][0]", fmv(1, 0, 0), -65536);
    check("rotz [1][1][1]", fmv(1, 1, 1), -65536);
    check("rotz [3][0][0]", fmv(3, 0, 0), 65536);
    check("rotz [3][0][1]", fmv(3, 0, 1), 0);

    set_mats(3); run_op("diag16", 0, 1'b0);
    check("diag16 [1][0][0]", fmv(1, 0, 0), 16777216);
    check("diag16 [2][0][0]", fmv(2, 0, 0), 67108863);

    // Abort mid-operation with results in flight.
    set_mats(4);
    en = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 1; i < 40; i++) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort busy", longint'(busy), 0);
    check("abort done", longint'(done), 0);
    check("abort fm", longint'(fm != '0), 0);
    repeat (10) @(posedge clk);
    #1;
    check("abort fm stays zero", longint'(fm != '0), 0);
    check("abort stays idle", longint'(busy), 0);
    set_mats(4); run_op("after_abort", 0, 1'b0);

    set_mats(4); run_op("en_gaps", 10, 1'b1);

    for (int i = 0; i < 3; i++) begin
      set_mats(4); run_op($sformatf("rand_small%0d", i), $urandom_range(4), 1'b1);
    end
    for (int i = 0; i < 2; i++) begin
      set_mats(5); run_op($sformatf("rand_sat%0d", i), 0, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
